ped_button_conditioner: RTL and testbench
=========================================

# ped_button_conditioner

Front-end stage for the pedestrian crossing controller. It takes the raw, asynchronous, bouncing pedestrian push-button input and synchronises and debounces it. Each debounced press becomes a latched crossing request, which drives the controller's `ped_button_pressed` input as a level. The request stays latched until the controller acknowledges it, and a "WAIT" indicator lamp follows the request.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: number of flip-flops in the synchroniser chain on `button_raw`. Minimum 2.
- `DEBOUNCE_CYCLES`, default 1000000: stable cycles required before a level change is accepted (20 ms at 50 MHz). Minimum 2.
- `CNT_W`, default 20: debounce counter width. Must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  asynchronous active-low reset.
- `button_raw`  in  1  raw push-button, active-high, asynchronous to `clk`, may bounce.
- `ped_ack`  in  1  one-cycle pulse from the controller when it accepts the request (on leaving car-green).
- `ped_request`  out  1  latched crossing request; connects to the controller's `ped_button_pressed`.
- `wait_lamp`  out  1  "WAIT" indicator; always equal to `ped_request`.
- `btn_clean`  out  1  debounced button level.
- `press_pulse`  out  1  one-cycle pulse per accepted press.
- `press_count`  out  8  count of accepted presses, saturating at 255.

## Operation

Synchroniser:
- `button_raw` passes through `SYNC_STAGES` flops, all reset to 0.
- The last stage is `btn_sync`. Only `btn_sync` feeds the logic below.

Debounce FSM has four states and a counter `cnt`:
- RELEASED: `btn_clean`=0. If `btn_sync`=1, go to PRESS_CHECK with `cnt`←0.
- PRESS_CHECK: if `btn_sync`=0, return to RELEASED with `cnt`←0 (bounce rejected).
  - Otherwise, if `cnt`=DEBOUNCE_CYCLES−1, go to HELD: `btn_clean`←1 and `press_pulse`←1 for one cycle.
  - Otherwise `cnt`←`cnt`+1.
- HELD: `btn_clean`=1. If `btn_sync`=0, go to RELEASE_CHECK with `cnt`←0.
- RELEASE_CHECK: if `btn_sync`=1, return to HELD (no new pulse).
  - Otherwise, if `cnt`=DEBOUNCE_CYCLES−1, go to RELEASED with `btn_clean`←0.
  - Otherwise `cnt`←`cnt`+1.
- Any unused state encoding returns to RELEASED.
- Holding the button indefinitely produces exactly one `press_pulse`. A new press requires a full debounced release first.

Request latch:
- `ped_request` sets on `press_pulse` and clears on `ped_ack`.
- If `press_pulse` and `ped_ack` occur in the same cycle, set wins and `ped_request` stays 1.
- A `ped_ack` arriving while `ped_request`=0 is ignored.
- Further presses while `ped_request`=1 keep it at 1; they do not queue.

Counter:
- `press_count` increments on each `press_pulse` and holds at 255.

## Timing

- Reset values (asynchronous, while `rst_n`=0): all synchroniser flops 0, FSM in RELEASED, `cnt`=0, `btn_clean`=0, `press_pulse`=0, `ped_request`=0, `wait_lamp`=0, `press_count`=0.
- Reset asserted mid-debounce or mid-request drops all of the above within the reset assertion. No pulse is emitted on release of reset, even if `button_raw`=1.
- Press latency: call the first edge that samples `button_raw`=1 edge 1, with the input held stable afterwards.
  - `btn_sync` rises after edge `SYNC_STAGES`.
  - `btn_clean` and `press_pulse` rise after edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`+1.
  - `ped_request` rises one edge later.
- Release latency: `btn_clean` falls `SYNC_STAGES`+`DEBOUNCE_CYCLES`+1 edges after the first edge sampling 0.
- Acknowledge latency: `ped_request` falls on the edge after the edge that samples `ped_ack`=1 (registered).
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan

All scenarios use `SYNC_STAGES`=2 and `DEBOUNCE_CYCLES`=4.

1. Reset: hold `rst_n`=0 with `button_raw`=1, then release. All outputs stay 0 through reset; `btn_clean`=1 appears 7 edges after release, with no glitch pulse.
2. Clean press: raise `button_raw` and hold it for 20 cycles. `press_pulse` is high for exactly one cycle, after edge 7. `ped_request`=1 and `wait_lamp`=1 after edge 8. `press_count`=1.
3. Bounce: toggle `button_raw` 1,0,1,0 every 2 cycles, then leave it at 0. No `press_pulse`; `btn_clean` stays 0; `press_count`=0.
4. Acknowledge: with `ped_request`=1, pulse `ped_ack` for one cycle. `ped_request` is 0 on the next edge. A second pulse while `ped_request`=0 leaves all outputs unchanged.
5. Simultaneous set and clear: align `ped_ack` with `press_pulse`. `ped_request` stays 1 and `press_count` increments.
6. Hold and saturation: holding the button for 100 cycles gives exactly one pulse. Then 260 clean press/release cycles leave `press_count`=255.

Source files
------------

// File: rtl/ped_button_conditioner.sv
// Pedestrian push-button front end: synchroniser, debounce FSM, request latch
// and saturating press counter. All outputs come straight from flops.
module ped_button_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button_raw,
  input  logic       ped_ack,
  output logic       ped_request,
  output logic       wait_lamp,
  output logic       btn_clean,
  output logic       press_pulse,
  output logic [7:0] press_count
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StReleased     = 2'd0,
    StPressCheck   = 2'd1,
    StHeld         = 2'd2,
    StReleaseCheck = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button_raw};
    end
  end

  assign btn_sync = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_clean_q, btn_clean_d;
  logic             press_pulse_q, press_pulse_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StReleased;
      cnt_q         <= '0;
      btn_clean_q   <= 1'b0;
      press_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      btn_clean_q   <= btn_clean_d;
      press_pulse_q <= press_pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StReleased: begin
        if (btn_sync) begin
          state_d = StPressCheck;
          cnt_d   = '0;
        end
      end
      StPressCheck: begin
        if (!btn_sync) begin
          state_d = StReleased;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StHeld;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StHeld: begin
        if (!btn_sync) begin
          state_d = StReleaseCheck;
          cnt_d   = '0;
        end
      end
      StReleaseCheck: begin
        if (btn_sync) begin
          state_d = StHeld;
        end else if (cnt_q == CntMax) begin
          state_d = StReleased;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StReleased;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change on
  // the same edge the FSM enters the corresponding state.
  always_comb begin
    btn_clean_d   = (state_d == StHeld) || (state_d == StReleaseCheck);
    press_pulse_d = (state_q == StPressCheck) && (state_d == StHeld);
  end

  // ---------------------------------------------------------------------------
  // Request latch and press counter
  // ---------------------------------------------------------------------------
  logic       req_q;
  logic [7:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= 1'b0;
    end else if (press_pulse_q) begin
      req_q <= 1'b1;  // set dominates a coincident acknowledge
    end else if (ped_ack) begin
      req_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (press_pulse_q && (count_q != 8'hFF)) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign ped_request = req_q;
  assign wait_lamp   = req_q;
  assign btn_clean   = btn_clean_q;
  assign press_pulse = press_pulse_q;
  assign press_count = count_q;

endmodule

// File: tb/tb_ped_button_conditioner.sv
// Bench for ped_button_conditioner: run-length reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_ped_button_conditioner;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       button_raw = 1'b0;
  logic       ped_ack = 1'b0;
  logic       ped_request, wait_lamp, btn_clean, press_pulse;
  logic [7:0] press_count;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;

  ped_button_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .button_raw (button_raw),
    .ped_ack    (ped_ack),
    .ped_request(ped_request),
    .wait_lamp  (wait_lamp),
    .btn_clean  (btn_clean),
    .press_pulse(press_pulse),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the synchronised level is the raw sample from SYNC-1
  // edges earlier; the clean level flips once the synchronised level has
  // disagreed with it for DEB+1 consecutive samples.
  int unsigned m_edge  = 0;
  int          m_run   = 0;
  logic        m_clean = 1'b0;
  logic        m_pulse = 1'b0;
  logic        m_req   = 1'b0;
  int          m_count = 0;
  logic        hist [64];

  function automatic logic synced(input int unsigned e);
    return (e >= SYNC) ? hist[(e - SYNC + 1) % 64] : 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edge  <= 0;
      m_run   <= 0;
      m_clean <= 1'b0;
      m_pulse <= 1'b0;
      m_req   <= 1'b0;
      m_count <= 0;
    end else begin
      m_edge                  <= m_edge + 1;
      hist[(m_edge + 1) % 64] <= button_raw;
      if (synced(m_edge) != m_clean) begin
        if (m_run + 1 == int'(DEB) + 1) begin
          m_clean <= !m_clean;
          m_pulse <= !m_clean;
          m_run   <= 0;
        end else begin
          m_run   <= m_run + 1;
          m_pulse <= 1'b0;
        end
      end else begin
        m_run   <= 0;
        m_pulse <= 1'b0;
      end
      if (m_pulse) m_req <= 1'b1;
      else if (ped_ack) m_req <= 1'b0;
      if (m_pulse && m_count < 255) m_count <= m_count + 1;
    end
  end

  always @(negedge clk) begin
    chk("model_btn_clean", btn_clean, m_clean);
    chk("model_press_pulse", press_pulse, m_pulse);
    chk("model_ped_request", ped_request, m_req);
    chk("model_wait_lamp", wait_lamp, m_req);
    chk("model_press_count", press_count, m_count);
  end

  task automatic step(input logic raw, input logic ack);
    button_raw = raw;
    ped_ack    = ack;
    @(posedge clk);
    #2;
    if (press_pulse) n_pulses++;
  endtask

  task automatic steps(input int n, input logic raw);
    for (int i = 0; i < n; i++) step(raw, 1'b0);
  endtask

  initial begin
    // 1. Reset with the button held
    #1 rst_n = 1'b0;
    button_raw = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_btn_clean", btn_clean, 0);
    chk("rst_pulse", press_pulse, 0);
    chk("rst_request", ped_request, 0);
    chk("rst_count", press_count, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0);
      chk("rst_no_early_clean", btn_clean, 0);
      chk("rst_no_glitch_pulse", press_pulse, 0);
    end
    step(1'b1, 1'b0);
    chk("rst_clean_edge7", btn_clean, 1);
    chk("rst_pulse_edge7", press_pulse, 1);
    chk("rst_req_edge7", ped_request, 0);
    step(1'b1, 1'b0);
    chk("rst_req_edge8", ped_request, 1);
    chk("rst_count_1", press_count, 1);
    steps(10, 1'b0);
    chk("release_clean", btn_clean, 0);
    chk("release_keeps_req", ped_request, 1);

    // 4. Acknowledge, then a stray acknowledge
    step(1'b0, 1'b1);
    chk("ack_clears_req", ped_request, 0);
    chk("ack_clears_lamp", wait_lamp, 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("stray_ack_req", ped_request, 0);
    chk("stray_ack_clean", btn_clean, 0);
    chk("stray_ack_count", press_count, 1);

    // 2. Clean press held 20 cycles
    n_pulses = 0;
    steps(6, 1'b1);
    chk("press_no_pulse_edge6", press_pulse, 0);
    step(1'b1, 1'b0);
    chk("press_pulse_edge7", press_pulse, 1);
    step(1'b1, 1'b0);
    chk("press_req_edge8", ped_request, 1);
    chk("press_lamp_edge8", wait_lamp, 1);
    chk("press_pulse_gone", press_pulse, 0);
    steps(12, 1'b1);
    chk("press_one_pulse", n_pulses, 1);
    chk("press_count_2", press_count, 2);
    steps(10, 1'b0);

    // 3. Bounce shorter than the debounce window
    n_pulses = 0;
    steps(2, 1'b1);
    steps(2, 1'b0);
    steps(2, 1'b1);
    steps(12, 1'b0);
    chk("bounce_no_pulse", n_pulses, 0);
    chk("bounce_clean", btn_clean, 0);
    chk("bounce_count", press_count, 2);

    // 5. Acknowledge coincident with the press pulse
    step(1'b0, 1'b1);
    chk("pre_sim_req_clear", ped_request, 0);
    steps(7, 1'b1);
    chk("sim_pulse_high", press_pulse, 1);
    step(1'b1, 1'b1);
    chk("sim_set_wins", ped_request, 1);
    chk("sim_count_3", press_count, 3);
    steps(10, 1'b0);

    // 6. Long hold, then saturation
    n_pulses = 0;
    steps(100, 1'b1);
    chk("hold_one_pulse", n_pulses, 1);
    chk("hold_count_4", press_count, 4);
    steps(10, 1'b0);
    for (int i = 0; i < 260; i++) begin
      steps(8, 1'b1);
      steps(8, 1'b0);
    end
    chk("sat_count_255", press_count, 255);
    chk("sat_req_held", ped_request, 1);

    // Reset mid-debounce while a request is latched
    steps(4, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", ped_request, 0);
    chk("midrst_lamp", wait_lamp, 0);
    chk("midrst_clean", btn_clean, 0);
    chk("midrst_count", press_count, 0);
    button_raw = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    steps(8, 1'b0);
    chk("post_rst_count", press_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
